// File: rtl/mem_store_buffer_if.sv
// mem_store_buffer_if
// Bundles the request side (from the EX/MEM register) and the data-memory
// port side of the posted-store buffer into a single interface.
//
// Request signals (driven by the pipeline, modport master -> slave):
//   i_flush, i_valid, i_mem_wr_rd, i_mem_wr_src, i_mem_rd_src,
//   i_alu_res (address), i_bus_b (store data)
// Response / memory-port signals (driven by the buffer, slave -> master):
//   o_stall, o_mem_wr_rd, o_mem_wr_src, o_mem_rd_src, o_alu_res, o_bus_b,
//   o_fwd_valid, o_fwd_data, o_count, o_empty
interface mem_store_buffer_if #(
  parameter int IO_BUS_SIZE = 32,
  parameter int DEPTH_LOG2  = 2
);
  logic                   i_flush;
  logic                   i_valid;
  logic                   i_mem_wr_rd;
  logic [1:0]             i_mem_wr_src;
  logic [2:0]             i_mem_rd_src;
  logic [IO_BUS_SIZE-1:0] i_alu_res;
  logic [IO_BUS_SIZE-1:0] i_bus_b;

  logic                   o_stall;
  logic                   o_mem_wr_rd;
  logic [1:0]             o_mem_wr_src;
  logic [2:0]             o_mem_rd_src;
  logic [IO_BUS_SIZE-1:0] o_alu_res;
  logic [IO_BUS_SIZE-1:0] o_bus_b;
  logic                   o_fwd_valid;
  logic [IO_BUS_SIZE-1:0] o_fwd_data;
  logic [DEPTH_LOG2:0]    o_count;
  logic                   o_empty;

  // The store buffer itself sits on the slave side.
  modport slave (
    input  i_flush, i_valid, i_mem_wr_rd, i_mem_wr_src, i_mem_rd_src,
           i_alu_res, i_bus_b,
    output o_stall, o_mem_wr_rd, o_mem_wr_src, o_mem_rd_src, o_alu_res,
           o_bus_b, o_fwd_valid, o_fwd_data, o_count, o_empty
  );

  // The pipeline / test environment drives requests from the master side.
  modport master (
    output i_flush, i_valid, i_mem_wr_rd, i_mem_wr_src, i_mem_rd_src,
           i_alu_res, i_bus_b,
    input  o_stall, o_mem_wr_rd, o_mem_wr_src, o_mem_rd_src, o_alu_res,
           o_bus_b, o_fwd_valid, o_fwd_data, o_count, o_empty
  );
endinterface

// File: rtl/mem_store_buffer.sv
// mem_store_buffer
// Posted-store buffer between the EX/MEM register and the single-port data
// memory. Stores are queued in a small circular FIFO and drained into the
// memory port whenever no load needs it; loads that alias a queued store
// stall until that store has drained.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_reset  - asynchronous, active-low reset (discards queued stores)
//   bus      - mem_store_buffer_if.slave: request inputs, memory-port
//              outputs, stall, forwarding result, occupancy count/empty
//
// Optional feature (macro STORE_BUFFER_FWD_EN): a full-word load hitting a
// queued full-word store is answered directly from the buffer instead of
// stalling. Without the macro o_fwd_valid / o_fwd_data stay 0.
module mem_store_buffer #(
  parameter int         IO_BUS_SIZE   = 32,
  parameter int         MEM_ADDR_SIZE = 5,
  parameter int         DEPTH_LOG2    = 2,
  parameter logic [1:0] WR_SRC_WORD   = 2'b10,
  parameter logic [2:0] RD_SRC_WORD   = 3'b010
) (
  input logic             i_clk,
  input logic             i_reset,
  mem_store_buffer_if.slave bus
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam int                  ADDR_PAD   = IO_BUS_SIZE - MEM_ADDR_SIZE;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PTR_ONE    = (DEPTH_LOG2+1)'(1);

  logic [DEPTH_LOG2:0]      wr_ptr;
  logic [DEPTH_LOG2:0]      rd_ptr;
  logic [DEPTH_LOG2:0]      count;
  logic [DEPTH_LOG2-1:0]    wr_idx;
  logic [DEPTH_LOG2-1:0]    rd_idx;
  logic [DEPTH_LOG2-1:0]    scan_idx;

  logic [MEM_ADDR_SIZE-1:0] entry_addr   [DEPTH];
  logic [IO_BUS_SIZE-1:0]   entry_data   [DEPTH];
  logic [1:0]               entry_wr_src [DEPTH];

  logic                     empty;
  logic                     full;
  logic                     req;
  logic                     is_store;
  logic                     is_load;
  logic                     push;
  logic                     drain;
  logic                     load_issue;
  logic                     hazard;
  logic                     young_word;
  logic [IO_BUS_SIZE-1:0]   young_data;
  logic                     fwd_en;
  logic                     fwd;
  logic [MEM_ADDR_SIZE-1:0] load_addr;

  logic                     port_wr_rd;
  logic [1:0]               port_wr_src;
  logic [2:0]               port_rd_src;
  logic [IO_BUS_SIZE-1:0]   port_alu_res;
  logic [IO_BUS_SIZE-1:0]   port_bus_b;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count  = wr_ptr - rd_ptr;
  assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx = rd_ptr[DEPTH_LOG2-1:0];
  assign empty  = (count == '0);
  assign full   = (count == FULL_COUNT);

  assign req       = bus.i_valid & ~bus.i_flush;
  assign is_store  = req & bus.i_mem_wr_rd;
  assign is_load   = req & ~bus.i_mem_wr_rd;
  assign push      = is_store & ~full;
  assign load_addr = bus.i_alu_res[MEM_ADDR_SIZE-1:0];

  // Scan occupied slots from oldest to youngest; the last hit left standing
  // is the youngest matching store, which is the one a forward must return.
  always_comb begin
    hazard     = 1'b0;
    young_word = 1'b0;
    young_data = '0;
    scan_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_idx + DEPTH_LOG2'(k);
      if (((DEPTH_LOG2+1)'(k) < count) && (entry_addr[scan_idx] == load_addr)) begin
        hazard     = 1'b1;
        young_word = (entry_wr_src[scan_idx] == WR_SRC_WORD);
        young_data = entry_data[scan_idx];
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign fwd_en = 1'b1;
`else
  assign fwd_en = 1'b0;
`endif

  // Only a word load over a word store can be satisfied from one entry.
  assign fwd = fwd_en & is_load & hazard & young_word &
               (bus.i_mem_rd_src == RD_SRC_WORD);

  assign load_issue = is_load & ~hazard;

  // Single memory port: an issuing load wins, otherwise the head drains.
  // A forwarded load never touches the port, so draining continues.
  always_comb begin
    port_wr_rd   = 1'b0;
    port_wr_src  = '0;
    port_rd_src  = '0;
    port_alu_res = '0;
    port_bus_b   = '0;
    drain        = 1'b0;
    if (load_issue) begin
      port_alu_res = bus.i_alu_res;
      port_rd_src  = bus.i_mem_rd_src;
    end else if (!empty) begin
      port_wr_rd   = 1'b1;
      port_alu_res = {{ADDR_PAD{1'b0}}, entry_addr[rd_idx]};
      port_bus_b   = entry_data[rd_idx];
      port_wr_src  = entry_wr_src[rd_idx];
      drain        = 1'b1;
    end
  end

  assign bus.o_mem_wr_rd  = port_wr_rd;
  assign bus.o_mem_wr_src = port_wr_src;
  assign bus.o_mem_rd_src = port_rd_src;
  assign bus.o_alu_res    = port_alu_res;
  assign bus.o_bus_b      = port_bus_b;
  assign bus.o_stall      = (is_store & full) | (is_load & hazard & ~fwd);
  assign bus.o_fwd_valid  = fwd;
  assign bus.o_fwd_data   = fwd ? young_data : '0;
  assign bus.o_count      = count;
  assign bus.o_empty      = empty;

  // Push and pop are independent; doing both leaves the count unchanged.
  // A freshly pushed entry is only visible to the drain logic next cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        entry_addr[k]   <= '0;
        entry_data[k]   <= '0;
        entry_wr_src[k] <= '0;
      end
    end else begin
      if (push) begin
        entry_addr[wr_idx]   <= load_addr;
        entry_data[wr_idx]   <= bus.i_bus_b;
        entry_wr_src[wr_idx] <= bus.i_mem_wr_src;
        wr_ptr               <= wr_ptr + PTR_ONE;
      end
      if (drain) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule
